// File: rtl/array_ops_pkg.sv
// rtl/array_ops_pkg.sv - shared sizing helpers and FSM state type for array tiling
package array_ops_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // A single tile still needs a one-bit index port.
    function automatic int tile_width(input int num_tiles);
        return (num_tiles <= 1) ? 1 : $clog2(num_tiles);
    endfunction

endpackage

// File: rtl/array_tile_extract.sv
// rtl/array_tile_extract.sv - selects one row-tile of the array and flattens it
module array_tile_extract
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4,
    parameter int COL_MAJOR = 1,
    localparam int NUM_TILES = ceil_div(ROWS, SUB_ROWS),
    localparam int TW        = tile_width(NUM_TILES)
) (
    input  logic [ROWS*COLS*BIT_WIDTH-1:0]     array,
    input  logic [TW-1:0]                      tile,
    output logic [SUB_ROWS*COLS*BIT_WIDTH-1:0] data,
    output logic [SUB_ROWS-1:0]                keep
);

    localparam int ROW_W    = COLS * BIT_WIDTH;
    localparam int PAD_ROWS = NUM_TILES * SUB_ROWS;

    logic [PAD_ROWS*ROW_W-1:0] padded;
    logic [ROW_W-1:0]          tile_rows [SUB_ROWS];

    // Rows past the end of the array read as zero so the last tile needs no special case.
    always_comb begin
        padded = '0;
        padded[ROWS*ROW_W-1:0] = array;
    end

    always_comb begin
        keep = '0;
        for (int i = 0; i < SUB_ROWS; i++) begin
            tile_rows[i] = '0;
            for (int t = 0; t < NUM_TILES; t++) begin
                if (tile == TW'(t)) begin
                    tile_rows[i] = padded[(t*SUB_ROWS + i)*ROW_W +: ROW_W];
                    keep[i]      = (t*SUB_ROWS + i < ROWS);
                end
            end
        end
    end

    for (genvar gi = 0; gi < SUB_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            localparam int SLOT = (COL_MAJOR != 0) ? (gj*SUB_ROWS + gi) : (gi*COLS + gj);
            assign data[SLOT*BIT_WIDTH +: BIT_WIDTH] = tile_rows[gi][gj*BIT_WIDTH +: BIT_WIDTH];
        end
    end

endmodule

// File: rtl/array_tile_serializer.sv
// rtl/array_tile_serializer.sv - captures a full array and streams it out as row-tiles
module array_tile_serializer
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4,
    parameter int COL_MAJOR = 1,
    localparam int NUM_TILES = ceil_div(ROWS, SUB_ROWS),
    localparam int TW        = tile_width(NUM_TILES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ROWS*COLS*BIT_WIDTH-1:0]     in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SUB_ROWS*COLS*BIT_WIDTH-1:0] out_data,
    output logic [SUB_ROWS-1:0]                out_keep,
    output logic [TW-1:0]                      out_tile,
    output logic                               out_last
);

    if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
        $error("array_tile_serializer: SUB_ROWS must be in 1..ROWS");
    end

    state_t                         state;
    logic [TW-1:0]                  tile;
    logic [ROWS*COLS*BIT_WIDTH-1:0] array_q;
    logic [SUB_ROWS*COLS*BIT_WIDTH-1:0] ext_data;
    logic [SUB_ROWS-1:0]            ext_keep;
    logic                           last_tile;
    logic                           in_fire;
    logic                           out_fire;

    assign last_tile = (tile == TW'(NUM_TILES - 1));
    assign out_valid = (state == SEND);

    // Accepting on the final beat's handshake lets arrays stream with no idle cycle between them.
    assign in_ready = rst_n && ((state == IDLE) || ((state == SEND) && last_tile && out_ready));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tile    <= '0;
            array_q <= '0;
        end else if (in_fire) begin
            array_q <= in_data;
            tile    <= '0;
            state   <= SEND;
        end else if (out_fire) begin
            if (last_tile) begin
                state <= IDLE;
            end else begin
                tile <= tile + TW'(1);
            end
        end
    end

    array_tile_extract #(
        .BIT_WIDTH (BIT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .SUB_ROWS  (SUB_ROWS),
        .COL_MAJOR (COL_MAJOR)
    ) u_extract (
        .array (array_q),
        .tile  (tile),
        .data  (ext_data),
        .keep  (ext_keep)
    );

    assign out_data = out_valid ? ext_data : '0;
    assign out_keep = out_valid ? ext_keep : '0;
    assign out_last = out_valid && last_tile;
    assign out_tile = tile;

endmodule

// File: tb/tb_array_tile_serializer.sv
// tb/tb_array_tile_serializer.sv - self-checking bench for array_tile_serializer
module tb_array_tile_serializer;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         tile;
        logic         last;
    } beat_t;

    typedef struct {
        int         sel;
        int         tile;
        int         slot;
        logic [3:0] elem;
        logic [3:0] keep;
        logic       last;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [255:0] in_data;

    logic         a_in_ready, a_out_valid, a_out_last, a_out_tile;
    logic [127:0] a_out_data;
    logic [3:0]   a_out_keep;
    logic         b_in_ready, b_out_valid, b_out_last, b_out_tile;
    logic [127:0] b_out_data;
    logic [3:0]   b_out_keep;
    logic         c_in_ready, c_out_valid, c_out_last, c_out_tile;
    logic [127:0] c_out_data;
    logic [3:0]   c_out_keep;

    int checks = 0;
    int passed = 0;
    beat_t q_a[$];
    beat_t q_c[$];
    beat_t ea, ec;

    always #5 clk = ~clk;

    array_tile_serializer dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_keep(a_out_keep), .out_tile(a_out_tile), .out_last(a_out_last)
    );

    array_tile_serializer #(.ROWS(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data[191:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_keep(b_out_keep), .out_tile(b_out_tile), .out_last(b_out_last)
    );

    array_tile_serializer #(.COL_MAJOR(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_keep(c_out_keep), .out_tile(c_out_tile), .out_last(c_out_last)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [127:0] model_data(input logic [255:0] arr, input int rows,
                                                input bit cm, input int t);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++)
                if (t*4 + i < rows)
                    d[(cm ? j*4 + i : i*8 + j)*4 +: 4] = arr[((t*4 + i)*8 + j)*4 +: 4];
        return d;
    endfunction

    function automatic logic [255:0] rand_arr();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: beats queued on every input handshake, retired on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_out_valid && out_ready) begin
                if (q_a.size() == 0) check("a_unexpected_beat", 1, 0);
                else begin
                    ea = q_a.pop_front();
                    check("sb_a_data", a_out_data, ea.data);
                    check("sb_a_keep", a_out_keep, ea.keep);
                    check("sb_a_tile", a_out_tile, ea.tile);
                    check("sb_a_last", a_out_last, ea.last);
                end
            end
            if (c_out_valid && out_ready) begin
                if (q_c.size() == 0) check("c_unexpected_beat", 1, 0);
                else begin
                    ec = q_c.pop_front();
                    check("sb_c_data", c_out_data, ec.data);
                    check("sb_c_tile", c_out_tile, ec.tile);
                    check("sb_c_last", c_out_last, ec.last);
                end
            end
            if (in_valid && a_in_ready) begin
                for (int t = 0; t < 2; t++) begin
                    q_a.push_back('{model_data(in_data, 8, 1'b1, t), 4'hF, t[0], t == 1});
                    q_c.push_back('{model_data(in_data, 8, 1'b0, t), 4'hF, t[0], t == 1});
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((q_a.size() != 0 || a_out_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_time", n < 40, 1);
        check("drain_queues_empty", q_a.size() + q_c.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         tbl[14];
        logic [255:0] pat, ra, rb;
        logic [127:0] d;
        logic [3:0]   kp;
        logic         l;
        int           cur;

        tbl[0]  = '{0, 0, 6,  4'd1,  4'hF, 1'b0};
        tbl[1]  = '{0, 0, 0,  4'd0,  4'hF, 1'b0};
        tbl[2]  = '{0, 0, 31, 4'd15, 4'hF, 1'b0};
        tbl[3]  = '{1, 0, 6,  4'd1,  4'hF, 1'b0};
        tbl[4]  = '{2, 0, 11, 4'd11, 4'hF, 1'b0};
        tbl[5]  = '{2, 0, 26, 4'd10, 4'hF, 1'b0};
        tbl[6]  = '{0, 1, 5,  4'd9,  4'hF, 1'b1};
        tbl[7]  = '{0, 1, 30, 4'd7,  4'hF, 1'b1};
        tbl[8]  = '{1, 1, 5,  4'd9,  4'h3, 1'b1};
        tbl[9]  = '{1, 1, 2,  4'd0,  4'h3, 1'b1};
        tbl[10] = '{1, 1, 31, 4'd0,  4'h3, 1'b1};
        tbl[11] = '{1, 1, 4,  4'd1,  4'h3, 1'b1};
        tbl[12] = '{2, 1, 9,  4'd9,  4'hF, 1'b1};
        tbl[13] = '{2, 1, 31, 4'd15, 4'hF, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #12;
        check("rst_in_ready", a_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_keep", a_out_keep, 0);
        check("rst_out_last", a_out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", a_in_ready, 1);
        check("post_rst_out_valid", a_out_valid, 0);
        check("post_rst_out_tile", a_out_tile, 0);

        // Orderings and partial last tile, stepped one beat at a time.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                pat[(r*8 + c)*4 +: 4] = 4'((r*8 + c) % 16);
        in_data = pat; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency_valid", a_out_valid, 1);
        cur = 0;
        for (int n = 0; n < 14; n++) begin
            if (tbl[n].tile != cur) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                cur = tbl[n].tile;
            end
            case (tbl[n].sel)
                0:       begin d = a_out_data; kp = a_out_keep; l = a_out_last; end
                1:       begin d = b_out_data; kp = b_out_keep; l = b_out_last; end
                default: begin d = c_out_data; kp = c_out_keep; l = c_out_last; end
            endcase
            check($sformatf("tbl%0d_elem", n), d[tbl[n].slot*4 +: 4], tbl[n].elem);
            check($sformatf("tbl%0d_keep", n), kp, tbl[n].keep);
            check($sformatf("tbl%0d_last", n), l, tbl[n].last);
        end
        drain();

        // Back-pressure on beat 0 with a competing array offered.
        ra = rand_arr();
        in_data = ra; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = ~ra;
        for (int k = 0; k < 5; k++) begin
            check("stall_data", a_out_data, model_data(ra, 8, 1'b1, 0));
            check("stall_tile", a_out_tile, 0);
            check("stall_in_ready", a_in_ready, 0);
            check("stall_valid", a_out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Back-to-back arrays with no bubble.
        ra = rand_arr(); rb = rand_arr();
        in_data = ra; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = rb;
        for (int k = 0; k < 4; k++) begin
            check("b2b_valid", a_out_valid, 1);
            check("b2b_tile", a_out_tile, k % 2);
            check("b2b_in_ready", a_in_ready, k % 2);
            if (k == 2) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b_idle_after", a_out_valid, 0);
        drain();

        // Reset while beat 0 is presented.
        ra = rand_arr();
        in_data = ra; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("prereset_valid", a_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_in_ready", a_in_ready, 0);
        q_a.delete(); q_c.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rerst_in_ready", a_in_ready, 1);
        check("rerst_out_valid", a_out_valid, 0);
        rb = rand_arr();
        in_data = rb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rerst_first_tile", a_out_tile, 0);
        check("rerst_first_data", a_out_data, model_data(rb, 8, 1'b1, 0));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
